// File: rtl/pll_reconfig_pkg.sv
// Shared types and widths for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    localparam int unsigned NUM_OUTPUTS = 6;
    localparam int unsigned MULT_W      = 7;
    localparam int unsigned DIV_W       = 8;
    localparam int unsigned PHASE_W     = 9;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_VCO,
        ST_VCO_WAIT,
        ST_OUT_SCAN,
        ST_OUT_CMD,
        ST_OUT_WAIT,
        ST_FINISH,
        ST_LOCK_WAIT,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_CMD_TIMEOUT  = 2'd1,
        ERR_LOCK_TIMEOUT = 2'd2
    } err_code_e;

    // States in which the timeout counter runs.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_VCO_WAIT) || (s == ST_OUT_WAIT) || (s == ST_LOCK_WAIT);
    endfunction

endpackage

// File: rtl/pll_reconfig_sequencer_timeout.sv
// Wait-state cycle counter; expired_c is high once the count reaches the limit.
module pll_timeout_counter #(
    parameter int unsigned CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired_c
);

    logic [CNT_W-1:0] r_count;

    assign o_expired_c = (r_count == i_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Drives one full runtime reconfiguration of the PLL: start, VCO command,
// per-output commands for the masked outputs, finish, then waits for relock.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned CMD_TIMEOUT  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 262144
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [MULT_W-1:0]                cfg_vco_mult,
    input  logic [MULT_W-1:0]                cfg_vco_indiv,
    input  logic                             cfg_vco_bandwidth,
    input  logic [NUM_OUTPUTS-1:0]           cfg_out_mask,
    input  logic [NUM_OUTPUTS*DIV_W-1:0]     cfg_out_div,
    input  logic [NUM_OUTPUTS*PHASE_W-1:0]   cfg_out_phase,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic                             pll_reconfig_start,
    output logic                             pll_reconfig_finish,
    output logic                             pll_reconfig_vco_en,
    output logic                             pll_reconfig_output_en,
    output logic [MULT_W-1:0]                pll_vco_mult,
    output logic [MULT_W-1:0]                pll_vco_indiv,
    output logic                             pll_vco_bandwidth,
    output logic [IDX_W-1:0]                 pll_output_idx,
    output logic [DIV_W-1:0]                 pll_output_div,
    output logic [PHASE_W-1:0]               pll_output_phase,
    input  logic                             pll_cmd_done,
    input  logic                             pll_busy,
    input  logic                             pll_locked
);

    localparam int unsigned MAX_TIMEOUT = (LOCK_TIMEOUT > CMD_TIMEOUT) ? LOCK_TIMEOUT : CMD_TIMEOUT;
    localparam int unsigned CNT_W       = $clog2(MAX_TIMEOUT + 1);

    state_e                                r_state, w_state_next;
    err_code_e                             r_err_code, w_err_next;
    logic [IDX_W-1:0]                      r_idx, w_idx_next;
    logic                                  w_accept;
    logic [NUM_OUTPUTS-1:0]                w_pending;
    logic [CNT_W-1:0]                      w_limit;
    logic                                  w_expired_c;
    logic                                  w_in_wait;

    logic [MULT_W-1:0]                     r_mult, r_indiv;
    logic                                  r_bw;
    logic [NUM_OUTPUTS-1:0]                r_mask;
    logic [NUM_OUTPUTS-1:0][DIV_W-1:0]     r_div;
    logic [NUM_OUTPUTS-1:0][PHASE_W-1:0]   r_phase;
    logic [IDX_W-1:0]                      r_out_idx;
    logic [DIV_W-1:0]                      r_out_div;
    logic [PHASE_W-1:0]                    r_out_phase;
    logic                                  r_ready, r_done, r_error;
    logic                                  r_start, r_finish, r_vco_en, r_output_en;

    // Outputs still to be programmed, starting at the current index.
    assign w_pending = r_mask >> r_idx;
    assign w_in_wait = is_wait_state(r_state);
    assign w_limit   = (r_state == ST_LOCK_WAIT) ? CNT_W'(LOCK_TIMEOUT) : CNT_W'(CMD_TIMEOUT);

    pll_timeout_counter #(
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (!w_in_wait),
        .i_enable    (w_in_wait),
        .i_limit     (w_limit),
        .o_expired_c (w_expired_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; completion wins over a timeout expiring in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = r_err_code;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_accept     = 1'b1;
                    w_err_next   = ERR_NONE;
                    w_state_next = ST_START;
                end
            end
            ST_START: w_state_next = ST_VCO;
            ST_VCO:   w_state_next = ST_VCO_WAIT;
            ST_VCO_WAIT: begin
                if (pll_cmd_done) begin
                    w_idx_next   = '0;
                    w_state_next = ST_OUT_SCAN;
                end else if (w_expired_c) begin
                    w_err_next   = ERR_CMD_TIMEOUT;
                    w_state_next = ST_ERR;
                end
            end
            ST_OUT_SCAN: begin
                if (w_pending == '0) begin
                    w_state_next = ST_FINISH;
                end else if (w_pending[0]) begin
                    w_state_next = ST_OUT_CMD;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            ST_OUT_CMD: w_state_next = ST_OUT_WAIT;
            ST_OUT_WAIT: begin
                if (pll_cmd_done) begin
                    w_idx_next   = r_idx + IDX_W'(1);
                    w_state_next = ST_OUT_SCAN;
                end else if (w_expired_c) begin
                    w_err_next   = ERR_CMD_TIMEOUT;
                    w_state_next = ST_ERR;
                end
            end
            ST_FINISH: w_state_next = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (!pll_busy && pll_locked) begin
                    w_state_next = ST_DONE;
                end else if (w_expired_c) begin
                    w_err_next   = ERR_LOCK_TIMEOUT;
                    w_state_next = ST_ERR;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Registered strobes, status, config latch and per-output command fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_start     <= 1'b0;
            r_finish    <= 1'b0;
            r_vco_en    <= 1'b0;
            r_output_en <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_idx       <= '0;
            r_mult      <= '0;
            r_indiv     <= '0;
            r_bw        <= 1'b0;
            r_mask      <= '0;
            r_div       <= '0;
            r_phase     <= '0;
            r_out_idx   <= '0;
            r_out_div   <= '0;
            r_out_phase <= '0;
        end else begin
            r_ready     <= (w_state_next == ST_IDLE);
            r_done      <= (w_state_next == ST_DONE);
            r_error     <= (w_state_next == ST_ERR);
            r_start     <= (w_state_next == ST_START);
            r_finish    <= (w_state_next == ST_FINISH);
            r_vco_en    <= (w_state_next == ST_VCO);
            r_output_en <= (w_state_next == ST_OUT_CMD);
            r_err_code  <= w_err_next;
            r_idx       <= w_idx_next;
            if (w_accept) begin
                r_mult  <= cfg_vco_mult;
                r_indiv <= cfg_vco_indiv;
                r_bw    <= cfg_vco_bandwidth;
                r_mask  <= cfg_out_mask;
                r_div   <= cfg_out_div;
                r_phase <= cfg_out_phase;
            end
            if (w_state_next == ST_OUT_CMD) begin
                r_out_idx   <= r_idx;
                r_out_div   <= r_div[r_idx];
                r_out_phase <= r_phase[r_idx];
            end
        end
    end

    assign cfg_ready              = r_ready;
    assign done                   = r_done;
    assign error                  = r_error;
    assign err_code               = r_err_code;
    assign pll_reconfig_start     = r_start;
    assign pll_reconfig_finish    = r_finish;
    assign pll_reconfig_vco_en    = r_vco_en;
    assign pll_reconfig_output_en = r_output_en;
    assign pll_vco_mult           = r_mult;
    assign pll_vco_indiv          = r_indiv;
    assign pll_vco_bandwidth      = r_bw;
    assign pll_output_idx         = r_out_idx;
    assign pll_output_div         = r_out_div;
    assign pll_output_phase       = r_out_phase;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench: stimulus pushes the expected PLL-port event stream, a
// negedge monitor pops and compares every strobe/done/error the DUT presents.
module tb_pll_reconfig_sequencer;

    localparam int unsigned CMD_TO  = 40;
    localparam int unsigned LOCK_TO = 100;
    localparam int K_START = 0, K_VCO = 1, K_OUT = 2, K_FIN = 3, K_DONE = 4, K_ERR = 5;

    typedef struct { int kind; int a; int b; int c; } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [6:0]  cfg_vco_mult = '0;
    logic [6:0]  cfg_vco_indiv = '0;
    logic        cfg_vco_bandwidth = 1'b0;
    logic [5:0]  cfg_out_mask = '0;
    logic [47:0] cfg_out_div = '0;
    logic [53:0] cfg_out_phase = '0;
    logic        done, error;
    logic [1:0]  err_code;
    logic        pll_reconfig_start, pll_reconfig_finish, pll_reconfig_vco_en, pll_reconfig_output_en;
    logic [6:0]  pll_vco_mult, pll_vco_indiv;
    logic        pll_vco_bandwidth;
    logic [2:0]  pll_output_idx;
    logic [7:0]  pll_output_div;
    logic [8:0]  pll_output_phase;
    logic        pll_cmd_done = 1'b0;
    logic        pll_busy = 1'b0;
    logic        pll_locked = 1'b1;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  last_done_cyc = 0, last_err_cyc = 0, last_fin_cyc = 0, last_out_cyc = 0;
    int  resp_delay = 1;
    int  hang_idx = -1;
    int  resp_cnt = 0;

    pll_reconfig_sequencer #(
        .CMD_TIMEOUT  (CMD_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_vco_mult           (cfg_vco_mult),
        .cfg_vco_indiv          (cfg_vco_indiv),
        .cfg_vco_bandwidth      (cfg_vco_bandwidth),
        .cfg_out_mask           (cfg_out_mask),
        .cfg_out_div            (cfg_out_div),
        .cfg_out_phase          (cfg_out_phase),
        .done                   (done),
        .error                  (error),
        .err_code               (err_code),
        .pll_reconfig_start     (pll_reconfig_start),
        .pll_reconfig_finish    (pll_reconfig_finish),
        .pll_reconfig_vco_en    (pll_reconfig_vco_en),
        .pll_reconfig_output_en (pll_reconfig_output_en),
        .pll_vco_mult           (pll_vco_mult),
        .pll_vco_indiv          (pll_vco_indiv),
        .pll_vco_bandwidth      (pll_vco_bandwidth),
        .pll_output_idx         (pll_output_idx),
        .pll_output_div         (pll_output_div),
        .pll_output_phase       (pll_output_phase),
        .pll_cmd_done           (pll_cmd_done),
        .pll_busy               (pll_busy),
        .pll_locked             (pll_locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int k, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.a = a; e.b = b; e.c = c;
        return e;
    endfunction

    task automatic push(input int k, input int a, input int b, input int c);
        exp_q.push_back(mk(k, a, b, c));
    endtask

    task automatic chk(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_ev(input ev_t act);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d, required none (cycle %0d)",
                     act.kind, act.a, act.b, act.c, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != act.kind || e.a != act.a || e.b != act.b || e.c != act.c) begin
                miscompares++;
                $display("FAIL event: got kind=%0d a=%0d b=%0d c=%0d, required kind=%0d a=%0d b=%0d c=%0d (cycle %0d)",
                         act.kind, act.a, act.b, act.c, e.kind, e.a, e.b, e.c, cyc);
            end
        end
    endtask

    // Monitor: every presented strobe/status pulse is one scoreboard vector.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pll_reconfig_start) check_ev(mk(K_START, 0, 0, 0));
            if (pll_reconfig_vco_en)
                check_ev(mk(K_VCO, int'(pll_vco_mult), int'(pll_vco_indiv), int'(pll_vco_bandwidth)));
            if (pll_reconfig_output_en) begin
                last_out_cyc = cyc;
                check_ev(mk(K_OUT, int'(pll_output_idx), int'(pll_output_div), int'(pll_output_phase)));
            end
            if (pll_reconfig_finish) begin
                last_fin_cyc = cyc;
                check_ev(mk(K_FIN, 0, 0, 0));
            end
            if (done) begin
                last_done_cyc = cyc;
                check_ev(mk(K_DONE, int'(err_code), 0, 0));
            end
            if (error) begin
                last_err_cyc = cyc;
                check_ev(mk(K_ERR, int'(err_code), 0, 0));
            end
        end
    end

    // PLL model: cmd_done pulse resp_delay cycles after each command strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_cnt     = 0;
            pll_cmd_done = 1'b0;
        end else begin
            pll_cmd_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) pll_cmd_done = 1'b1;
            end
            if (pll_reconfig_vco_en || (pll_reconfig_output_en && int'(pll_output_idx) != hang_idx))
                resp_cnt = resp_delay;
        end
    end

    task automatic push_seq(input int mult, input int indiv, input int bw, input logic [5:0] mask,
                            input logic [47:0] dv, input logic [53:0] ph, input int hang, input bit lock_fail);
        push(K_START, 0, 0, 0);
        push(K_VCO, mult, indiv, bw);
        for (int i = 0; i < 6; i++) begin
            if (mask[i]) begin
                push(K_OUT, i, int'(dv[8*i +: 8]), int'(ph[9*i +: 9]));
                if (i == hang) begin
                    push(K_ERR, 1, 0, 0);
                    return;
                end
            end
        end
        push(K_FIN, 0, 0, 0);
        if (lock_fail) push(K_ERR, 2, 0, 0);
        else           push(K_DONE, 0, 0, 0);
    endtask

    task automatic drive(input int mult, input int indiv, input int bw, input logic [5:0] mask,
                         input logic [47:0] dv, input logic [53:0] ph);
        cfg_vco_mult      = 7'(mult);
        cfg_vco_indiv     = 7'(indiv);
        cfg_vco_bandwidth = 1'(bw);
        cfg_out_mask      = mask;
        cfg_out_div       = dv;
        cfg_out_phase     = ph;
    endtask

    // Called at a negedge; returns at the negedge after acceptance, acc = accept cycle.
    task automatic send(input int mult, input int indiv, input int bw, input logic [5:0] mask,
                        input logic [47:0] dv, input logic [53:0] ph, output int acc);
        int n;
        drive(mult, indiv, bw, mask, dv, ph);
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept ready", int'(cfg_ready), 1);
        acc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cfg_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " events outstanding"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, n, strobes;
        logic [47:0] dv;
        logic [53:0] ph;

        // Reset values
        repeat (3) @(negedge clk);
        strobes = int'(pll_reconfig_start) + int'(pll_reconfig_finish)
                + int'(pll_reconfig_vco_en) + int'(pll_reconfig_output_en);
        chk("rst cfg_ready", int'(cfg_ready), 1);
        chk("rst strobes", strobes, 0);
        chk("rst done+error", int'(done) + int'(error), 0);
        chk("rst err_code", int'(err_code), 0);
        chk("rst vco_mult", int'(pll_vco_mult), 0);
        chk("rst output_div", int'(pll_output_div), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: mask 000101, responses 3 cycles after each strobe
        dv = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        ph = {9'd300, 9'd250, 9'd200, 9'd150, 9'd100, 9'd511};
        resp_delay = 3;
        push_seq(40, 1, 1, 6'b000101, dv, ph, -1, 1'b0);
        send(40, 1, 1, 6'b000101, dv, ph, acc);
        wait_quiet("t1", 300);
        chk("t1 err_code", int'(err_code), 0);

        // 2: mask 0, instant responses, accept->done latency
        resp_delay = 1;
        push_seq(25, 3, 0, 6'b000000, dv, ph, -1, 1'b0);
        send(25, 3, 0, 6'b000000, dv, ph, acc);
        wait_quiet("t2", 100);
        chk("t2 accept-to-done cycles", last_done_cyc - acc, 7);

        // 3: output idx 1 never completes -> command timeout
        hang_idx = 1;
        push_seq(12, 2, 1, 6'b000110, dv, ph, 1, 1'b0);
        send(12, 2, 1, 6'b000110, dv, ph, acc);
        wait_quiet("t3", 500);
        chk("t3 strobe-to-error cycles", last_err_cyc - last_out_cyc, int'(CMD_TO) + 2);
        chk("t3 cfg_ready", int'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        chk("t3 err_code held", int'(err_code), 1);
        hang_idx = -1;

        // 4: never locks -> lock timeout; next accept clears err_code
        pll_locked = 1'b0;
        push_seq(64, 5, 0, 6'b001000, dv, ph, -1, 1'b1);
        send(64, 5, 0, 6'b001000, dv, ph, acc);
        wait_quiet("t4", 1000);
        chk("t4 finish-to-error cycles", last_err_cyc - last_fin_cyc, int'(LOCK_TO) + 2);
        chk("t4 err_code held", int'(err_code), 2);
        pll_locked = 1'b1;
        push_seq(33, 4, 1, 6'b000000, dv, ph, -1, 1'b0);
        send(33, 4, 1, 6'b000000, dv, ph, acc);
        chk("t4 err_code cleared on accept", int'(err_code), 0);
        wait_quiet("t4b", 100);

        // 5: reset while waiting on an output command
        resp_delay = 20;
        push(K_START, 0, 0, 0);
        push(K_VCO, 99, 7, 1);
        push(K_OUT, 0, 10, 511);
        send(99, 7, 1, 6'b000001, dv, ph, acc);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5 events before reset", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        strobes = int'(pll_reconfig_start) + int'(pll_reconfig_finish)
                + int'(pll_reconfig_vco_en) + int'(pll_reconfig_output_en);
        chk("t5 strobes in reset", strobes, 0);
        chk("t5 cfg_ready in reset", int'(cfg_ready), 1);
        chk("t5 vco_mult in reset", int'(pll_vco_mult), 0);
        chk("t5 output_phase in reset", int'(pll_output_phase), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5 cfg_ready after release", int'(cfg_ready), 1);
        resp_delay = 1;
        push_seq(77, 6, 0, 6'b100001, dv, ph, -1, 1'b0);
        send(77, 6, 0, 6'b100001, dv, ph, acc);
        wait_quiet("t5b", 200);

        // 6: cfg_valid held with churning fields; only first request reaches PLL
        resp_delay = 2;
        push_seq(45, 9, 1, 6'b000010, dv, ph, -1, 1'b0);
        push_seq(17, 8, 0, 6'b010000, dv, ph, -1, 1'b0);
        drive(45, 9, 1, 6'b000010, dv, ph);
        cfg_valid = 1'b1;
        chk("t6 ready before first", int'(cfg_ready), 1);
        @(negedge clk);
        n = 0;
        while (!cfg_ready && n < 200) begin
            drive(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
                  6'($urandom), {$urandom, 16'($urandom)}, {22'($urandom), $urandom});
            @(negedge clk);
            n++;
        end
        drive(17, 8, 0, 6'b010000, dv, ph);
        acc_b = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("t6 second accept after done", acc_b - last_done_cyc, 1);
        wait_quiet("t6", 200);

        chk("final scoreboard empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
